// File: rtl/pwm_duty_ctrl.sv
// pwm_duty_ctrl
// Parses 3-byte duty-set frames (header, D, ~D) from the UART receiver and
// slews the PWM duty toward the commanded target one percent at a time.
// Corrupted or stalled frames are dropped with a frame_err pulse and never
// move the duty.
module pwm_duty_ctrl #(
  parameter int         clk_mhz    = 50,
  parameter int         ramp_us    = 100,
  parameter int         timeout_us = 1000,
  parameter logic [7:0] header     = 8'hA5,
  parameter int         max_duty   = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [6:0] duty,
  output logic       duty_upd,
  output logic       busy,
  output logic       frame_err
);

  localparam int RAMP_CYCLES    = clk_mhz * ramp_us;
  localparam int TIMEOUT_CYCLES = clk_mhz * timeout_us;
  localparam int RW = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [RW-1:0] RAMP_LAST    = RW'((RAMP_CYCLES > 0) ? RAMP_CYCLES - 1 : 0);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [7:0]    MAX_DUTY8    = 8'(max_duty);
  localparam logic [6:0]    MAX_DUTY7    = 7'(max_duty);

  typedef enum logic [1:0] {
    IDLE,
    GOT_HDR,
    GOT_DUTY
  } state_t;

  state_t        state, state_d;
  logic [7:0]    data, data_d;
  logic [6:0]    target, target_d;
  logic [TW-1:0] tcnt, tcnt_d;
  logic          err_d;
  logic [RW-1:0] rcnt, rcnt_d;
  logic [6:0]    duty_d;
  logic          upd_d;
  logic          busy_d;

  // Frame parser: next state, latched data byte, target and timeout counter.
  // A byte arriving in the expiry cycle takes priority over the timeout.
  always_comb begin
    state_d  = state;
    data_d   = data;
    target_d = target;
    tcnt_d   = tcnt;
    err_d    = 1'b0;
    case (state)
      IDLE: begin
        tcnt_d = '0;
        if (rx_valid && (rx_data == header)) begin
          state_d = GOT_HDR;
        end
      end
      GOT_HDR, GOT_DUTY: begin
        if (rx_valid) begin
          tcnt_d = '0;
          if (state == GOT_HDR) begin
            data_d  = rx_data;
            state_d = GOT_DUTY;
          end else begin
            state_d = IDLE;
            if (rx_data == ~data) begin
              target_d = (data > MAX_DUTY8) ? MAX_DUTY7 : data[6:0];
            end else begin
              err_d = 1'b1;
            end
          end
        end else if ((TIMEOUT_CYCLES > 0) && (tcnt == TIMEOUT_LAST)) begin
          state_d = IDLE;
          tcnt_d  = '0;
          err_d   = 1'b1;
        end else if (TIMEOUT_CYCLES > 0) begin
          tcnt_d = tcnt + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tcnt_d  = '0;
      end
    endcase
  end

  // Slew limiter: one percent step per ramp period toward target; the period
  // counter keeps running across a retarget so the cadence is not disturbed.
  // busy tracks the post-step duty against the current target.
  always_comb begin
    duty_d = duty;
    upd_d  = 1'b0;
    rcnt_d = rcnt;
    if (RAMP_CYCLES == 0) begin
      rcnt_d = '0;
      if (duty != target) begin
        duty_d = target;
        upd_d  = 1'b1;
      end
    end else if (!busy || (duty == target)) begin
      rcnt_d = '0;
    end else if (rcnt == RAMP_LAST) begin
      rcnt_d = '0;
      upd_d  = 1'b1;
      duty_d = (target > duty) ? duty + 7'd1 : duty - 7'd1;
    end else begin
      rcnt_d = rcnt + RW'(1);
    end
    busy_d = (duty_d != target);
  end

  // State register for parser and ramp; reset abandons any frame or ramp.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      data      <= '0;
      target    <= '0;
      tcnt      <= '0;
      frame_err <= 1'b0;
      rcnt      <= '0;
      duty      <= '0;
      duty_upd  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      data      <= data_d;
      target    <= target_d;
      tcnt      <= tcnt_d;
      frame_err <= err_d;
      rcnt      <= rcnt_d;
      duty      <= duty_d;
      duty_upd  <= upd_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// tb_pwm_duty_ctrl
// Drives a ramping instance (ramp_us=2) and a jump instance (ramp_us=0) from
// the same byte stream and compares both against a frame/slew reference model.
module tb_pwm_duty_ctrl;

  localparam int         T    = 10;
  localparam int         R    = 2;
  localparam int         MAXD = 100;
  localparam logic [7:0] HDR  = 8'hA5;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [6:0] duty, duty0;
  logic       duty_upd, busy, frame_err;
  logic       duty_upd0, busy0, frame_err0;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc, last_byte, origin;
  int m_tgt, m_duty, m_busy, m0_duty;
  logic [7:0] frame_q[$];
  int busy_cnt, upd_cnt, err_cnt, upd0_cnt;

  pwm_duty_ctrl #(
    .clk_mhz(1), .ramp_us(R), .timeout_us(T), .header(HDR), .max_duty(MAXD)
  ) u_dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .duty(duty), .duty_upd(duty_upd), .busy(busy), .frame_err(frame_err)
  );

  pwm_duty_ctrl #(
    .clk_mhz(1), .ramp_us(0), .timeout_us(T), .header(HDR), .max_duty(MAXD)
  ) u_dut0 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .duty(duty0), .duty_upd(duty_upd0), .busy(busy0), .frame_err(frame_err0)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Watchdog so a stuck run still terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive the byte, predict the next outputs, compare.
  task automatic applyStimulus(input logic v, input logic [7:0] d);
    int  tgt_n, duty_n, busy_n, err_n, duty0_n;
    bit  step;
    rx_valid = v;
    rx_data  = d;
    tgt_n = m_tgt;
    err_n = 0;
    if (v) begin
      if (frame_q.size() == 0) begin
        if (d == HDR) frame_q.push_back(d);
      end else if (frame_q.size() == 1) begin
        frame_q.push_back(d);
      end else begin
        if (d == (frame_q[1] ^ 8'hFF))
          tgt_n = (int'(frame_q[1]) > MAXD) ? MAXD : int'(frame_q[1]);
        else
          err_n = 1;
        frame_q.delete();
      end
      last_byte = cyc;
    end else if ((frame_q.size() != 0) && (cyc - last_byte == T)) begin
      frame_q.delete();
      err_n = 1;
    end
    step = (m_busy != 0) && (m_duty != m_tgt) && (((cyc - origin) % R) == R - 1);
    duty_n  = step ? ((m_tgt > m_duty) ? m_duty + 1 : m_duty - 1) : m_duty;
    busy_n  = (duty_n != m_tgt) ? 1 : 0;
    duty0_n = m_tgt;
    if ((m_busy == 0) && (busy_n != 0)) origin = cyc + 1;
    @(posedge clk);
    #1;
    cyc++;
    checkOutput("duty", int'(duty), duty_n);
    checkOutput("duty_upd", int'(duty_upd), (duty_n != m_duty) ? 1 : 0);
    checkOutput("busy", int'(busy), busy_n);
    checkOutput("frame_err", int'(frame_err), err_n);
    checkOutput("duty_jump", int'(duty0), duty0_n);
    checkOutput("duty_upd_jump", int'(duty_upd0), (duty0_n != m0_duty) ? 1 : 0);
    checkOutput("busy_jump", int'(busy0), 0);
    checkOutput("frame_err_jump", int'(frame_err0), err_n);
    if (busy) busy_cnt++;
    if (duty_upd) upd_cnt++;
    if (frame_err) err_cnt++;
    if (duty_upd0) upd0_cnt++;
    m_tgt   = tgt_n;
    m_duty  = duty_n;
    m_busy  = busy_n;
    m0_duty = duty0_n;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 8'h00);
  endtask

  task automatic sendByte(input logic [7:0] d, input int gap);
    applyStimulus(1'b1, d);
    idle(gap);
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic [7:0] c, input int gap);
    sendByte(HDR, gap);
    sendByte(d, gap);
    sendByte(c, gap);
  endtask

  // Asynchronous reset between clock edges; outputs must clear at once.
  task automatic pulseReset();
    rx_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_duty", int'(duty), 0);
    checkOutput("async_rst_busy", int'(busy), 0);
    checkOutput("async_rst_duty_jump", int'(duty0), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_tgt = 0; m_duty = 0; m_busy = 0; m0_duty = 0;
    frame_q.delete();
  endtask

  initial begin
    int w;
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    cyc = 0; last_byte = 0; origin = 0;
    m_tgt = 0; m_duty = 0; m_busy = 0; m0_duty = 0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_duty", int'(duty), 0);
    checkOutput("reset_duty_upd", int'(duty_upd), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_frame_err", int'(frame_err), 0);
    checkOutput("reset_duty_jump", int'(duty0), 0);
    rst = 1'b0;

    $display("[TB] basic frame to 10");
    busy_cnt = 0; upd_cnt = 0; err_cnt = 0;
    sendFrame(8'h0A, 8'hF5, 2);
    idle(30);
    checkOutput("t1_busy_cycles", busy_cnt, 20);
    checkOutput("t1_upd_pulses", upd_cnt, 10);
    checkOutput("t1_frame_err", err_cnt, 0);
    checkOutput("t1_final_duty", int'(duty), 10);

    $display("[TB] clamp and bad checksum");
    sendFrame(8'hC8, 8'h37, 2);
    idle(200);
    checkOutput("t2_clamped_duty", int'(duty), 100);
    err_cnt = 0;
    sendFrame(8'h32, 8'h00, 2);
    idle(5);
    checkOutput("t2_bad_sum_err", err_cnt, 1);
    checkOutput("t2_duty_held", int'(duty), 100);

    $display("[TB] timeout handling");
    err_cnt = 0;
    sendByte(HDR, 12);
    checkOutput("t3_timeout_err", err_cnt, 1);
    sendByte(8'h0A, 2);
    sendByte(8'hF5, 2);
    checkOutput("t3_orphan_err", err_cnt, 1);
    checkOutput("t3_orphan_duty", int'(duty), 100);
    err_cnt = 0;
    sendByte(HDR, 9);
    sendByte(8'h32, 0);
    sendByte(8'hCD, 2);
    idle(110);
    checkOutput("t3_expiry_err", err_cnt, 0);
    checkOutput("t3_expiry_duty", int'(duty), 50);

    $display("[TB] retarget during ramp");
    sendFrame(8'h00, 8'hFF, 1);
    idle(105);
    sendFrame(8'h32, 8'hCD, 1);
    w = 0;
    while ((duty != 7'd20) && (w < 200)) begin
      idle(1);
      w++;
    end
    checkOutput("t4_reach_20", (duty == 7'd20) ? 1 : 0, 1);
    err_cnt = 0;
    sendFrame(8'h0A, 8'hF5, 1);
    idle(60);
    checkOutput("t4_reversed_duty", int'(duty), 10);
    sendByte(8'h00, 1);
    sendByte(8'hFF, 1);
    sendFrame(8'h0A, 8'hF5, 1);
    idle(5);
    checkOutput("t4_stray_err", err_cnt, 0);
    checkOutput("t4_stray_duty", int'(duty), 10);

    $display("[TB] reset mid-frame and mid-ramp");
    sendFrame(8'h50, 8'hAF, 1);
    idle(20);
    sendByte(HDR, 1);
    sendByte(8'h40, 0);
    pulseReset();
    sendFrame(8'h14, 8'hEB, 1);
    idle(50);
    checkOutput("t5_after_reset_duty", int'(duty), 20);
    checkOutput("t5_after_reset_busy", int'(busy), 0);

    $display("[TB] jump instance");
    upd0_cnt = 0;
    sendByte(HDR, 2);
    sendByte(8'h40, 2);
    sendByte(8'hBF, 0);
    checkOutput("t6_duty_before", int'(duty0), 20);
    idle(1);
    checkOutput("t6_duty_jump", int'(duty0), 64);
    idle(5);
    checkOutput("t6_single_upd", upd0_cnt, 1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 40; i++) begin
      int kind;
      logic [7:0] b, d, c;
      kind = int'($urandom_range(0, 9));
      if (kind < 2) begin
        b = 8'($urandom_range(0, 255));
        if (b == HDR) b = 8'h00;
        sendByte(b, int'($urandom_range(0, 3)));
      end else begin
        d = 8'($urandom_range(0, 255));
        c = d ^ 8'hFF;
        if (kind == 2) c = c ^ (8'h01 << $urandom_range(0, 7));
        sendByte(HDR, (kind == 3) ? int'($urandom_range(9, 12)) : int'($urandom_range(0, 4)));
        sendByte(d, int'($urandom_range(0, 4)));
        sendByte(c, int'($urandom_range(0, 2)));
      end
      idle(int'($urandom_range(0, 40)));
    end
    idle(220);
    checkOutput("final_settled_busy", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
